// File: rtl/dcc_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dcc_bus_arbiter_if
// Description : SH-2 system-bus arbitration handshake bundle. Carries the
//               request, grant and acknowledge lines between the arbiter and
//               the bus agents.
// Revision    : 1.0 - initial release
// ============================================================================
interface dcc_bus_arbiter_if;
    logic       BREQ_N;     // slave SH-2 bus request, active-low
    logic       EXBREQ_N;   // external (SCU) bus request, active-low
    logic       BGR_N;      // master SH-2 has released the bus, active-low
    logic       BRLS_N;     // release request to master SH-2, active-low
    logic       BACK_N;     // acknowledge to slave SH-2, active-low
    logic       EXBACK_N;   // acknowledge to external requester, active-low
    logic [1:0] OWNER;      // 0 master, 1 slave, 2 external

    // Arbiter side: samples requests and master release, drives grants
    modport master (
        input  BREQ_N,
        input  EXBREQ_N,
        input  BGR_N,
        output BRLS_N,
        output BACK_N,
        output EXBACK_N,
        output OWNER
    );

    // Agent side: drives requests and master release, observes grants
    modport slave (
        output BREQ_N,
        output EXBREQ_N,
        output BGR_N,
        input  BRLS_N,
        input  BACK_N,
        input  EXBACK_N,
        input  OWNER
    );
endinterface
`default_nettype wire

// File: rtl/dcc_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dcc_bus_arbiter
// Description : Shared SH-2 bus arbiter. The master SH-2 owns the bus by
//               default; the slave SH-2 and the external requester obtain it
//               through a release-request / release / acknowledge sequence.
//               Round-robin between the two non-default requesters, with a
//               programmable idle gap after each tenure. All state advances
//               on the CE_R clock enable.
// Revision    : 1.0 - initial release
// ============================================================================
module dcc_bus_arbiter #(
    parameter int TURN_CYC = 1      // idle CE ticks after a release (1..15)
) (
    input  wire logic          CLK,
    input  wire logic          RST,
    input  wire logic          CE_R,
    dcc_bus_arbiter_if.master  bus
);

    localparam logic [3:0] TURN_LOAD = 4'(TURN_CYC);

    // Requester identity: 0 = slave SH-2, 1 = external
    localparam logic SEL_SLAVE = 1'b0;
    localparam logic SEL_EXT   = 1'b1;

    localparam logic [1:0] OWN_MASTER = 2'd0;
    localparam logic [1:0] OWN_SLAVE  = 2'd1;
    localparam logic [1:0] OWN_EXT    = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REL_REQ = 3'd1,
        ST_GRANT_S = 3'd2,
        ST_GRANT_X = 3'd3,
        ST_TURN    = 3'd4,
        ST_RETURN  = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic       win_q,   win_d;     // winner latched in IDLE
    logic       last_q,  last_d;    // most recently granted requester
    logic [3:0] cnt_q,   cnt_d;     // turnaround counter
    logic       brls_q,  brls_d;
    logic       back_q,  back_d;
    logic       exback_q, exback_d;
    logic [1:0] owner_q, owner_d;

    logic slave_req;
    logic ext_req;
    logic master_free;
    logic do_grant;
    logic grant_sel;

    assign slave_req   = ~bus.BREQ_N;
    assign ext_req     = ~bus.EXBREQ_N;
    assign master_free = ~bus.BGR_N;

    // Request level of a given requester
    function automatic logic req_of(input logic sel, input logic s_req, input logic x_req);
        return sel ? x_req : s_req;
    endfunction

    // Next-state and registered-output decode
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        brls_d    = brls_q;
        back_d    = back_q;
        exback_d  = exback_q;
        owner_d   = owner_q;
        do_grant  = 1'b0;
        grant_sel = SEL_SLAVE;

        case (state_q)
            ST_IDLE: begin
                if (slave_req || ext_req) begin
                    // On a tie the requester that did not own the bus last wins
                    if (slave_req && ext_req) begin
                        win_d = ~last_q;
                    end else begin
                        win_d = ext_req ? SEL_EXT : SEL_SLAVE;
                    end
                    brls_d  = 1'b0;
                    state_d = ST_REL_REQ;
                end
            end

            ST_REL_REQ: begin
                if (master_free) begin
                    if (req_of(win_q, slave_req, ext_req)) begin
                        do_grant  = 1'b1;
                        grant_sel = win_q;
                    end else if (req_of(~win_q, slave_req, ext_req)) begin
                        do_grant  = 1'b1;
                        grant_sel = ~win_q;
                    end else begin
                        // Winner withdrew and nobody else is waiting
                        brls_d  = 1'b1;
                        state_d = ST_RETURN;
                    end
                end
            end

            ST_GRANT_S: begin
                if (!slave_req) begin
                    back_d  = 1'b1;
                    owner_d = OWN_MASTER;
                    cnt_d   = TURN_LOAD;
                    state_d = ST_TURN;
                end
            end

            ST_GRANT_X: begin
                if (!ext_req) begin
                    exback_d = 1'b1;
                    owner_d  = OWN_MASTER;
                    cnt_d    = TURN_LOAD;
                    state_d  = ST_TURN;
                end
            end

            ST_TURN: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (req_of(~last_q, slave_req, ext_req)) begin
                    // Direct hand-off: master keeps its bus released
                    do_grant  = 1'b1;
                    grant_sel = ~last_q;
                end else begin
                    brls_d  = 1'b1;
                    state_d = ST_RETURN;
                end
            end

            ST_RETURN: begin
                if (!master_free) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Common grant action shared by REL_REQ and TURN
        if (do_grant) begin
            state_d  = grant_sel ? ST_GRANT_X : ST_GRANT_S;
            back_d   = grant_sel;
            exback_d = ~grant_sel;
            owner_d  = grant_sel ? OWN_EXT : OWN_SLAVE;
            last_d   = grant_sel;
        end
    end

    // State and output registers, advancing only on the clock enable
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            win_q    <= SEL_SLAVE;
            last_q   <= SEL_EXT;
            cnt_q    <= 4'd0;
            brls_q   <= 1'b1;
            back_q   <= 1'b1;
            exback_q <= 1'b1;
            owner_q  <= OWN_MASTER;
        end else if (CE_R) begin
            state_q  <= state_d;
            win_q    <= win_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            brls_q   <= brls_d;
            back_q   <= back_d;
            exback_q <= exback_d;
            owner_q  <= owner_d;
        end
    end

    assign bus.BRLS_N   = brls_q;
    assign bus.BACK_N   = back_q;
    assign bus.EXBACK_N = exback_q;
    assign bus.OWNER    = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_dcc_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcc_bus_arbiter
// Description : Scoreboard bench for dcc_bus_arbiter. Stimulus pushes each
//               expected output change with the clock edge it must follow;
//               a monitor pops on every observed output change.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcc_bus_arbiter;

    localparam int TURN_CYC = 2;

    // Output vector {BRLS_N, BACK_N, EXBACK_N, OWNER}
    localparam logic [4:0] V_IDLE = 5'b11100;
    localparam logic [4:0] V_REQ  = 5'b01100;   // also the TURN gap
    localparam logic [4:0] V_GS   = 5'b00101;
    localparam logic [4:0] V_GX   = 5'b01010;

    typedef struct {
        int         edge_n;
        logic [4:0] vec;
        string      name;
    } exp_t;

    bit   CLK = 1'b0;
    logic RST;
    logic CE_R;
    int   ec = 0;
    int   n_test = 0;
    int   n_fail = 0;
    exp_t q[$];
    logic [4:0] prev_vec = 5'bxxxxx;

    dcc_bus_arbiter_if bus ();

    dcc_bus_arbiter #(.TURN_CYC(TURN_CYC)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .CE_R (CE_R),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    // Edge counter used to timestamp expectations
    always @(posedge CLK) ec <= ec + 1;

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Expect the outputs to change to v right after edge ec+ofs
    task automatic expect_at(input int ofs, input logic [4:0] v, input string nm);
        exp_t e;
        e.edge_n = ec + ofs;
        e.vec    = v;
        e.name   = nm;
        q.push_back(e);
    endtask

    // Monitor: compare each observed output change against the scoreboard
    always @(negedge CLK) begin
        logic [4:0] cur;
        exp_t       e;
        if (ec > 0) begin
            cur = {bus.BRLS_N, bus.BACK_N, bus.EXBACK_N, bus.OWNER};
            if (cur !== prev_vec) begin
                n_test++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change edge=%0d got=%b required=none", ec, cur);
                end else begin
                    e = q.pop_front();
                    if (cur !== e.vec || ec != e.edge_n) begin
                        n_fail++;
                        $display("FAIL %s got vec=%b at edge %0d, required vec=%b at edge %0d",
                                 e.name, cur, ec, e.vec, e.edge_n);
                    end
                end
            end
            prev_vec = cur;
            if (q.size() > 0 && q[0].edge_n <= ec) begin
                e = q.pop_front();
                n_test++;
                n_fail++;
                $display("FAIL %s missed: vec=%b at edge %0d, required vec=%b at edge %0d",
                         e.name, cur, ec, e.vec, e.edge_n);
            end
            n_test++;
            if ((!bus.BACK_N && !bus.EXBACK_N) || bus.OWNER == 2'd3 ||
                ((!bus.BACK_N || !bus.EXBACK_N) && bus.BGR_N)) begin
                n_fail++;
                $display("FAIL invariant edge=%0d got vec=%b BGR_N=%b required exclusive acks with BGR_N low",
                         ec, cur, bus.BGR_N);
            end
        end
    end

    // Stimulus
    initial begin
        RST          = 1'b1;
        CE_R         = 1'b1;
        bus.BREQ_N   = 1'b1;
        bus.EXBREQ_N = 1'b1;
        bus.BGR_N    = 1'b1;
        expect_at(1, V_IDLE, "reset_state");
        step(2);
        RST = 1'b0;

        // Single slave request
        bus.BREQ_N = 1'b0;
        expect_at(1, V_REQ, "slave_rel_req");
        step(3);
        bus.BGR_N = 1'b0;
        expect_at(1, V_GS, "slave_grant");
        step(7);
        bus.BREQ_N = 1'b1;
        expect_at(1, V_REQ, "slave_release");
        expect_at(TURN_CYC + 2, V_IDLE, "slave_return");
        step(4);
        bus.BGR_N = 1'b1;
        step(2);

        // Simultaneous requests after reset, then fairness S,X,S,X
        RST = 1'b1;
        step(1);
        RST = 1'b0;
        bus.BREQ_N   = 1'b0;
        bus.EXBREQ_N = 1'b0;
        expect_at(1, V_REQ, "tie_rel_req");
        step(1);
        bus.BGR_N = 1'b0;
        expect_at(1, V_GS, "tie_slave_first");
        step(4);
        for (int t = 0; t < 3; t++) begin
            if (t % 2 == 0) begin
                bus.BREQ_N = 1'b1;
                expect_at(1, V_REQ, "rr_release_s");
                expect_at(TURN_CYC + 2, V_GX, "rr_grant_x");
                step(1);
                bus.BREQ_N = 1'b0;
            end else begin
                bus.EXBREQ_N = 1'b1;
                expect_at(1, V_REQ, "rr_release_x");
                expect_at(TURN_CYC + 2, V_GS, "rr_grant_s");
                step(1);
                bus.EXBREQ_N = 1'b0;
            end
            step(TURN_CYC + 3);
        end
        bus.BREQ_N   = 1'b1;
        bus.EXBREQ_N = 1'b1;
        expect_at(1, V_REQ, "rr_final_release");
        expect_at(TURN_CYC + 2, V_IDLE, "rr_return");
        step(TURN_CYC + 2);
        bus.BGR_N = 1'b1;
        step(3);

        // Withdrawal before grant
        bus.EXBREQ_N = 1'b0;
        expect_at(1, V_REQ, "wd_rel_req");
        step(1);
        bus.EXBREQ_N = 1'b1;
        step(2);
        bus.BGR_N = 1'b0;
        expect_at(1, V_IDLE, "wd_return");
        step(1);
        bus.BGR_N = 1'b1;
        step(2);
        bus.BREQ_N = 1'b0;
        expect_at(1, V_REQ, "wd_idle_reached");
        step(1);
        bus.BGR_N = 1'b0;
        expect_at(1, V_GS, "wd_next_grant");
        step(2);

        // Clock-enable gating mid-grant: nothing may change
        CE_R = 1'b0;
        step(1);
        bus.BREQ_N = 1'b1;
        step(2);
        bus.EXBREQ_N = 1'b0;
        step(2);
        bus.BREQ_N   = 1'b0;
        bus.EXBREQ_N = 1'b1;
        CE_R = 1'b1;
        step(2);

        // Hand off to external, then reset during GRANT_X
        bus.BREQ_N   = 1'b1;
        bus.EXBREQ_N = 1'b0;
        expect_at(1, V_REQ, "hx_release_s");
        expect_at(TURN_CYC + 2, V_GX, "hx_grant_x");
        step(TURN_CYC + 3);
        RST = 1'b1;
        expect_at(1, V_IDLE, "rst_mid_grant_x");
        step(1);
        RST = 1'b0;
        expect_at(1, V_REQ, "rst_rearb_req");
        expect_at(2, V_GX, "rst_rearb_grant");
        step(3);
        bus.EXBREQ_N = 1'b1;
        expect_at(1, V_REQ, "end_release_x");
        expect_at(TURN_CYC + 2, V_IDLE, "end_return");
        step(TURN_CYC + 2);
        bus.BGR_N = 1'b1;
        step(3);

        n_test++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/dcc_bus_arbiter.md
# dcc_bus_arbiter

Arbitrates ownership of the shared SH-2 system bus between the master SH-2 (default owner), the slave SH-2 and the external requester (SCU) inside the bus-control unit. It replaces the tied-off BRLS_N/BACK_N/EXBACK_N outputs with a real request/release/grant sequence. It uses round-robin fairness between the two non-default requesters and enforces a programmable turnaround gap between owners. All state advances on the CE_R clock enable.

## Interface
- TURN_CYC, 1, idle CE_R ticks between a requester's release and handing the bus back to the master (valid 1..15)
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- CE_R  in  1  rising-phase clock enable; FSM and all registers update only when high
- BREQ_N  in  1  slave SH-2 bus request, active-low
- EXBREQ_N  in  1  external (SCU) bus request, active-low
- BGR_N  in  1  master SH-2 bus-granted acknowledge, active-low (low = master has released the bus)
- BRLS_N  out  1  bus release request to master SH-2, active-low
- BACK_N  out  1  bus acknowledge to slave SH-2, active-low
- EXBACK_N  out  1  bus acknowledge to external requester, active-low
- OWNER  out  2  current owner: 0 master, 1 slave, 2 external (3 never driven)

## Operation
- States: IDLE, REL_REQ, GRANT_S, GRANT_X, TURN, RETURN.
- Reset (RST=1 at a CLK edge, regardless of CE_R): state IDLE, BRLS_N=1, BACK_N=1, EXBACK_N=1, OWNER=0, LAST=external (so the slave wins the first tie), turn counter=0.
- IDLE: if either request is low, latch the winner (WIN) and go to REL_REQ; BRLS_N goes low.
  - Only one requester low: that requester wins.
  - Both low: the requester other than LAST wins.
- REL_REQ: hold BRLS_N=0 until BGR_N=0 is sampled. Then:
  - If WIN's request is still low: grant WIN (GRANT_S or GRANT_X).
  - Else if the other request is low: grant the other.
  - Else: go to RETURN.
- GRANT_S / GRANT_X:
  - The matching ack is low and OWNER shows 1 or 2. LAST is updated to the granted requester.
  - Tenure is unlimited. When the owner's request is sampled high, the ack goes high, OWNER=0, the counter loads TURN_CYC, and the FSM goes to TURN.
- TURN: decrement the counter once per CE_R. When it reaches 0:
  - If the other requester is low, grant it directly. BRLS_N stays low and there is no master round-trip.
  - Otherwise go to RETURN.
- RETURN: BRLS_N=1. Wait until BGR_N=1 is sampled, then go to IDLE. Requests arriving during RETURN are held until IDLE.
- BACK_N and EXBACK_N are never low together. Neither is ever low while BGR_N is sampled high.

## Timing
- All outputs are registered and change only on a CLK edge with CE_R=1, except under reset.
- Request low sampled at CE tick N → BRLS_N low after tick N.
- BGR_N low sampled at tick M → ack low after tick M. Minimum request-to-ack latency is 2 CE ticks.
- Owner release sampled at tick K → ack high after K. A new ack is possible no earlier than tick K+TURN_CYC+1.
- BRLS_N is high after tick K+TURN_CYC+1 when no other request is pending.
- Requests are level-sensitive and must stay low until acked. A request withdrawn before grant is dropped silently.
- With CE_R=0 the state and outputs are frozen and inputs are ignored.
- Reset mid-tenure: all acks and BRLS_N are high on the next clock. A requester still holding its request low is re-arbitrated from IDLE.

## Test plan
- Single slave request: BREQ_N=0 at tick 0, BGR_N=0 at tick 3 → BRLS_N=0 after tick 0, BACK_N=0 and OWNER=1 after tick 3. BREQ_N=1 at tick 10 with TURN_CYC=2 → BACK_N=1 after tick 10, BRLS_N=1 after tick 13.
- Simultaneous requests after reset: BREQ_N=EXBREQ_N=0 → slave granted first. On slave release with EXBREQ_N still 0, EXBACK_N=0 after TURN_CYC ticks with BRLS_N held low throughout.
- Fairness: both requesters continuously re-requesting → grants alternate S,X,S,X over 4 tenures. Acks are never simultaneously low.
- Withdrawal: EXBREQ_N pulses low 1 tick, then BGR_N=0 with no request pending → no ack, BRLS_N returns high, FSM reaches IDLE after BGR_N=1.
- CE_R gating: CE_R=0 for 5 clocks mid-grant with request toggling → outputs unchanged.
- Reset during GRANT_X: RST=1 for one clock → EXBACK_N=1, BRLS_N=1, OWNER=0 on the next edge.
